feed_arbiter: RTL and testbench

FEED_ARBITER -- requirements
Module: feed_arbiter

---
 rtl/feed_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_feed_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_arbiter.sv
// Time-shares one ITCH parser between N_SRC byte-stream sources with
// message-atomic round-robin switching, abort handling and statistics.
module feed_arbiter #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_strobe,
    input  logic [N_SRC-1:0]     src_start,
    input  logic [N_SRC-1:0]     src_end,
    input  logic [N_SRC-1:0]     src_good,
    input  logic [8*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 start_msg,
    output logic                 end_msg,
    output logic                 valid,
    output logic [7:0]           message,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     msg_cnt,
    output logic [CNT_W-1:0]     abort_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int unsigned PTR_W = 3;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_id_q, grant_id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               start_msg_q, start_msg_d;
    logic               end_msg_q, end_msg_d;
    logic               valid_q, valid_d;
    logic [7:0]         message_q, message_d;
    logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [N_SRC-1:0]   cand, win_oh, gnt_oh, sel_oh;
    logic               found_hi, found_lo, any_cand;
    logic [PTR_W-1:0]   win_hi, win_lo, win_id;
    logic               sel_strobe, sel_start, sel_end, sel_good;
    logic [7:0]         sel_data;
    logic               idle_take, idle_drop, st_gap, st_restart, st_acc, st_end, st_over;
    logic               abort_ev;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_SRC - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin search: lowest candidate at/above rr_ptr, else lowest overall.
    always_comb begin
        cand     = src_strobe & src_start;
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = PTR_W'(i);
            end
            if (cand[i]) begin
                found_lo = 1'b1;
                win_lo   = PTR_W'(i);
            end
        end
        any_cand = found_lo;
        win_id   = found_hi ? win_hi : win_lo;
    end

    // Selected source lane: the winner in IDLE, the granted source in STREAM.
    always_comb begin
        win_oh = '0;
        gnt_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            win_oh[i] = any_cand && (win_id == PTR_W'(i));
            gnt_oh[i] = (grant_id_q == PTR_W'(i));
        end
        sel_oh     = (state_q == ST_IDLE) ? win_oh : gnt_oh;
        sel_strobe = |(src_strobe & sel_oh);
        sel_start  = |(src_start & sel_oh);
        sel_end    = |(src_end & sel_oh);
        sel_good   = |(src_good & sel_oh);
        sel_data   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_oh[i]) begin
                sel_data = src_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        idle_take  = (state_q == ST_IDLE) && any_cand;
        idle_drop  = (state_q == ST_IDLE) && (|(src_strobe & ~cand));
        st_gap     = (state_q == ST_STREAM) && !sel_strobe;
        st_restart = (state_q == ST_STREAM) && sel_strobe && sel_start;
        st_acc     = (state_q == ST_STREAM) && sel_strobe && !sel_start;
        st_end     = st_acc && sel_end;
        st_over    = st_acc && !sel_end && (len_q == LEN_W'(MAX_LEN - 1));
        abort_ev   = st_gap || st_restart || st_over;
    end

    // Non-candidates are always accepted in IDLE so stray bytes drain as drops.
    always_comb begin
        src_ready = '0;
        if (rst) begin
            src_ready = '0;
        end else if (state_q == ST_IDLE) begin
            src_ready = ~cand | win_oh;
        end else begin
            src_ready = gnt_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_take && !sel_end) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort_ev || st_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        len_d       = len_q;
        start_msg_d = 1'b0;
        end_msg_d   = 1'b0;
        valid_d     = 1'b0;
        message_d   = '0;
        msg_cnt_d   = msg_cnt_q;
        abort_cnt_d = abort_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (idle_take) begin
            start_msg_d = 1'b1;
            end_msg_d   = sel_end;
            valid_d     = sel_good;
            message_d   = sel_data;
            grant_id_d  = win_id;
            len_d       = LEN_W'(1);
            if (sel_end) begin
                rr_ptr_d = wrap_inc(win_id);
            end
        end
        if (idle_drop) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        // A length overrun still forwards its byte, flagged invalid and terminal.
        if (st_acc) begin
            end_msg_d = sel_end || st_over;
            valid_d   = sel_good && !st_over;
            message_d = sel_data;
            len_d     = len_q + LEN_W'(1);
        end
        if (st_gap || st_restart) begin
            end_msg_d = 1'b1;
        end
        if (abort_ev || st_end) begin
            rr_ptr_d = wrap_inc(grant_id_q);
        end

        if ((idle_take && sel_end) || st_end) begin
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
        end
        if (abort_ev && !(&abort_cnt_q)) begin
            abort_cnt_d = abort_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            len_q       <= '0;
            start_msg_q <= 1'b0;
            end_msg_q   <= 1'b0;
            valid_q     <= 1'b0;
            message_q   <= '0;
            msg_cnt_q   <= '0;
            abort_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            len_q       <= len_d;
            start_msg_q <= start_msg_d;
            end_msg_q   <= end_msg_d;
            valid_q     <= valid_d;
            message_q   <= message_d;
            msg_cnt_q   <= msg_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign start_msg = start_msg_q;
    assign end_msg   = end_msg_q;
    assign valid     = valid_q;
    assign message   = message_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == ST_STREAM);
    assign msg_cnt   = msg_cnt_q;
    assign abort_cnt = abort_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_feed_arbiter.sv
// Directed bench for feed_arbiter: forwarding, round-robin grant, aborts,
// length overrun, bad-byte passthrough and mid-message reset.
module tb_feed_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned ML = 64;
    localparam int unsigned CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_strobe, src_start, src_end, src_good, src_ready;
    logic [8*N-1:0]  src_data;
    logic            start_msg, end_msg, valid, busy;
    logic [7:0]      message;
    logic [2:0]      grant_id;
    logic [CW-1:0]   msg_cnt, abort_cnt, drop_cnt;

    int errors = 0;
    int checks = 0;

    feed_arbiter #(.N_SRC(N), .MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .src_strobe(src_strobe), .src_start(src_start), .src_end(src_end),
        .src_good(src_good), .src_data(src_data), .src_ready(src_ready),
        .start_msg(start_msg), .end_msg(end_msg), .valid(valid), .message(message),
        .grant_id(grant_id), .busy(busy),
        .msg_cnt(msg_cnt), .abort_cnt(abort_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ow();
        return {21'd0, start_msg, end_msg, valid, message};
    endfunction

    function automatic logic [31:0] pk(input logic s, input logic e, input logic v, input logic [7:0] d);
        return {21'd0, s, e, v, d};
    endfunction

    task automatic clr_in();
        src_strobe = '0;
        src_start  = '0;
        src_end    = '0;
        src_good   = '0;
        src_data   = '0;
    endtask

    task automatic drive(input logic [1:0] s, input logic st, input logic en, input logic gd,
                         input logic [7:0] d);
        src_strobe[s] = 1'b1;
        src_start[s]  = st;
        src_end[s]    = en;
        src_good[s]   = gd;
        src_data[{s, 3'b000} +: 8] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] s, input int len, input logic [7:0] first,
                            input logic [7:0] last, input int bad, input string tag);
        logic [7:0] d;
        for (int k = 1; k <= len; k++) begin
            d = (k == 1) ? first : ((k == len) ? last : 8'(k));
            clr_in();
            drive(s, k == 1, k == len, k != bad, d);
            #1;
            check({tag, " ready"}, 32'(src_ready[s]), 32'd1);
            tick();
            check(tag, ow(), pk(k == 1, k == len, k != bad, d));
        end
        clr_in();
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        clr_in();
        src_strobe = '1;
        src_start  = '1;
        #1;
        check("rst ready", 32'(src_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        clr_in();
        check("rst out", ow(), 32'd0);
        check("rst msg_cnt", 32'(msg_cnt), 32'd0);
        check("rst abort_cnt", 32'(abort_cnt), 32'd0);
        check("rst drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant", 32'(grant_id), 32'd0);

        // 36-byte message from source 0
        send_msg(2'd0, 36, 8'h41, 8'h03, 0, "A");
        check("A msg_cnt", 32'(msg_cnt), 32'd1);
        check("A rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
        check("A busy", 32'(busy), 32'd0);
        tick();
        check("A idle out", ow(), 32'd0);

        // Simultaneous starts from sources 0 and 2
        do_reset();
        clr_in(); drive(2'd0, 1, 0, 1, 8'h41); drive(2'd2, 1, 0, 1, 8'h53);
        #1 check("arb c1 ready", 32'(src_ready), 32'hB);
        tick();
        check("arb c1 out", ow(), pk(1, 0, 1, 8'h41));
        check("arb c1 grant", 32'(grant_id), 32'd0);
        check("arb c1 busy", 32'(busy), 32'd1);
        clr_in(); drive(2'd0, 0, 0, 1, 8'h42); drive(2'd2, 1, 0, 1, 8'h53);
        #1 check("arb c2 ready", 32'(src_ready), 32'h1);
        tick();
        check("arb c2 out", ow(), pk(0, 0, 1, 8'h42));
        clr_in(); drive(2'd0, 0, 1, 1, 8'h43); drive(2'd2, 1, 0, 1, 8'h53);
        #1 check("arb c3 ready", 32'(src_ready), 32'h1);
        tick();
        check("arb c3 out", ow(), pk(0, 1, 1, 8'h43));
        check("arb c3 msg_cnt", 32'(msg_cnt), 32'd1);
        check("arb c3 busy", 32'(busy), 32'd0);
        clr_in(); drive(2'd2, 1, 0, 1, 8'h53);
        #1 check("arb c4 ready", 32'(src_ready), 32'hF);
        tick();
        check("arb c4 out", ow(), pk(1, 0, 1, 8'h53));
        check("arb c4 grant", 32'(grant_id), 32'd2);
        clr_in(); drive(2'd2, 0, 1, 1, 8'h54);
        tick();
        check("arb c5 out", ow(), pk(0, 1, 1, 8'h54));
        check("arb c5 msg_cnt", 32'(msg_cnt), 32'd2);
        check("arb c5 rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
        clr_in(); drive(2'd0, 1, 1, 1, 8'h60); drive(2'd3, 1, 1, 1, 8'h61);
        #1 check("arb c6 ready", 32'(src_ready), 32'hE);
        tick();
        check("arb c6 out", ow(), pk(1, 1, 1, 8'h61));
        check("arb c6 grant", 32'(grant_id), 32'd3);
        clr_in();

        // Strobe gap at byte 10 of a 19-byte message from source 1
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            d = (k == 1) ? 8'h44 : 8'(k);
            clr_in(); drive(2'd1, k == 1, 0, 1, d);
            tick();
            check("D byte", ow(), pk(k == 1, 0, 1, d));
        end
        clr_in();
        tick();
        check("D abort out", ow(), pk(0, 1, 0, 8'h00));
        check("D abort_cnt", 32'(abort_cnt), 32'd1);
        check("D busy", 32'(busy), 32'd0);
        check("D msg_cnt", 32'(msg_cnt), 32'd0);
        check("D rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
        tick();
        check("D idle out", ow(), 32'd0);

        // 70-byte stream with no end from source 3
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            clr_in(); drive(2'd3, k == 1, 0, 1, 8'(k));
            tick();
            if (k <= ML) check("L70 byte", ow(), pk(k == 1, k == ML, k != ML, 8'(k)));
            else         check("L70 dropped out", ow(), 32'd0);
        end
        clr_in();
        check("L70 drop_cnt", 32'(drop_cnt), 32'd6);
        check("L70 abort_cnt", 32'(abort_cnt), 32'd1);
        check("L70 msg_cnt", 32'(msg_cnt), 32'd0);
        check("L70 busy", 32'(busy), 32'd0);

        // Exactly MAX_LEN bytes with end on the last one is a normal message
        do_reset();
        send_msg(2'd0, 64, 8'h42, 8'h0F, 0, "L64");
        check("L64 msg_cnt", 32'(msg_cnt), 32'd1);
        check("L64 abort_cnt", 32'(abort_cnt), 32'd0);
        clr_in(); drive(2'd1, 1, 1, 1, 8'h53);
        tick();
        check("single out", ow(), pk(1, 1, 1, 8'h53));
        check("single msg_cnt", 32'(msg_cnt), 32'd2);
        check("single busy", 32'(busy), 32'd0);
        clr_in();

        // Unexpected restart inside a message aborts it
        do_reset();
        clr_in(); drive(2'd0, 1, 0, 1, 8'h41);
        tick();
        clr_in(); drive(2'd0, 1, 0, 1, 8'h41);
        tick();
        check("restart abort_cnt", 32'(abort_cnt), 32'd1);
        check("restart busy", 32'(busy), 32'd0);
        check("restart msg_cnt", 32'(msg_cnt), 32'd0);
        clr_in();

        // Bad byte 16 inside a message from source 2
        do_reset();
        send_msg(2'd2, 20, 8'h46, 8'h0A, 16, "F");
        check("F msg_cnt", 32'(msg_cnt), 32'd1);
        check("F abort_cnt", 32'(abort_cnt), 32'd0);

        // Reset at byte 20 of a message from source 1
        for (int k = 1; k <= 19; k++) begin
            d = (k == 1) ? 8'h45 : 8'(k);
            clr_in(); drive(2'd1, k == 1, 0, 1, d);
            tick();
            check("E byte", ow(), pk(k == 1, 0, 1, d));
        end
        clr_in(); drive(2'd1, 0, 0, 1, 8'h14);
        rst = 1'b1;
        #1 check("E rst ready", 32'(src_ready), 32'd0);
        tick();
        check("E rst out", ow(), 32'd0);
        check("E rst msg_cnt", 32'(msg_cnt), 32'd0);
        check("E rst abort_cnt", 32'(abort_cnt), 32'd0);
        check("E rst drop_cnt", 32'(drop_cnt), 32'd0);
        check("E rst busy", 32'(busy), 32'd0);
        check("E rst grant", 32'(grant_id), 32'd0);
        rst = 1'b0;
        clr_in();
        send_msg(2'd3, 5, 8'h45, 8'h0D, 0, "E3");
        check("E3 msg_cnt", 32'(msg_cnt), 32'd1);
        check("E3 abort_cnt", 32'(abort_cnt), 32'd0);
        check("E3 grant", 32'(grant_id), 32'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
